branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/riscv_config_pkg.sv | 7 +
 rtl/riscv_types_pkg.sv | 14 +
 rtl/branch_resolve_queue.sv | 136 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_config_pkg.sv
// Core-wide configuration constants shared by the front-end and execute blocks.
package riscv_config_pkg;

  localparam int XLEN              = 32;
  localparam int DEFAULT_BRQ_DEPTH = 8;

endpackage : riscv_config_pkg

// File: rtl/riscv_types_pkg.sv
// Shared data types: address type and the branch-resolve-queue entry layout.
package riscv_types_pkg;

  import riscv_config_pkg::*;

  typedef logic [XLEN-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    logic  pred_taken;
    addr_t pred_target;
  } brq_entry_t;

endpackage : riscv_types_pkg

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time branch predictions, checked against execute
// results; emits a registered redirect on mispredict and a predictor update.
module branch_resolve_queue
  import riscv_config_pkg::*;
  import riscv_types_pkg::*;
#(
  parameter int DEPTH = DEFAULT_BRQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // alloc: an entry transfers on a rising edge where alloc_valid_i && alloc_ready_o.
  // resolve has no ready; it is consumed whenever the queue is non-empty.
  input  logic                     alloc_valid_i,
  output logic                     alloc_ready_o,
  input  logic [XLEN-1:0]          alloc_pc_i,
  input  logic                     alloc_pred_taken_i,
  input  logic [XLEN-1:0]          alloc_pred_target_i,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_is_branch_i,
  input  logic                     resolve_taken_i,
  input  logic [XLEN-1:0]          resolve_target_i,
  input  logic                     flush_i,
  output logic                     mispredict_o,
  output logic [XLEN-1:0]          redirect_pc_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     update_o,
  output logic [XLEN-1:0]          update_pc_o,
  output logic                     actual_taken_o,
  output logic [XLEN-1:0]          actual_target_o,
  output logic                     is_branch_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  brq_entry_t        mem_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [PW-1:0]     head_d, tail_d;
  logic [CW-1:0]     count_q, count_d;

  brq_entry_t        head_entry;
  logic              do_resolve;
  logic              do_alloc;
  logic              mispredict;
  logic              eff_taken;
  logic              kill;
  addr_t             redirect_pc;

  assign alloc_ready_o = (count_q < FULL_CNT);
  assign count_o       = count_q;
  assign head_entry    = mem_q[head_q];

  always_comb begin
    do_resolve  = resolve_valid_i && (count_q != '0);
    eff_taken   = resolve_is_branch_i && resolve_taken_i;
    mispredict  = 1'b0;
    if (resolve_is_branch_i) begin
      mispredict = (head_entry.pred_taken != resolve_taken_i) ||
                   (head_entry.pred_taken && resolve_taken_i &&
                    (head_entry.pred_target != resolve_target_i));
    end else begin
      // A non-branch that was predicted taken is a phantom branch.
      mispredict = head_entry.pred_taken;
    end
    redirect_pc = eff_taken ? resolve_target_i : (head_entry.pc + 32'd4);

    kill     = flush_i || (do_resolve && mispredict);
    do_alloc = alloc_valid_i && alloc_ready_o && !kill;

    head_d  = head_q + PW'(do_resolve);
    tail_d  = tail_q;
    count_d = count_q;
    if (kill) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      tail_d  = tail_q + PW'(do_alloc);
      count_d = count_q + CW'(do_alloc) - CW'(do_resolve);
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      mem_q[tail_q] <= '{pc: alloc_pc_i, pred_taken: alloc_pred_taken_i,
                         pred_target: alloc_pred_target_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mispredict_o    <= 1'b0;
      redirect_pc_o   <= '0;
      update_o        <= 1'b0;
      update_pc_o     <= '0;
      actual_taken_o  <= 1'b0;
      actual_target_o <= '0;
      is_branch_o     <= 1'b0;
    end else begin
      mispredict_o <= do_resolve && mispredict;
      update_o     <= do_resolve && resolve_is_branch_i;
      is_branch_o  <= do_resolve && resolve_is_branch_i;
      if (do_resolve) begin
        redirect_pc_o <= redirect_pc;
      end
      if (do_resolve && resolve_is_branch_i) begin
        update_pc_o     <= head_entry.pc;
        actual_taken_o  <= resolve_taken_i;
        actual_target_o <= resolve_target_i;
      end
    end
  end

  a_no_alloc_when_full : assert property (
    @(posedge clk_i) disable iff (rst_i) (count_q == FULL_CNT) |-> !do_alloc);

  a_count_bounded : assert property (
    @(posedge clk_i) disable iff (rst_i) count_q <= FULL_CNT);

  a_mispredict_after_resolve : assert property (
    @(posedge clk_i) disable iff (rst_i) mispredict_o |-> $past(do_resolve));

endmodule : branch_resolve_queue

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: vector table plus hand sequences
// for full/wrap, flush and mid-stream reset.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [31:0] alloc_pc_i;
  logic        alloc_pred_taken_i;
  logic [31:0] alloc_pred_target_i;
  logic        resolve_valid_i;
  logic        resolve_is_branch_i;
  logic        resolve_taken_i;
  logic [31:0] resolve_target_i;
  logic        flush_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [3:0]  count_o;
  logic        update_o;
  logic [31:0] update_pc_o;
  logic        actual_taken_o;
  logic [31:0] actual_target_o;
  logic        is_branch_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_pc_i(alloc_pc_i), .alloc_pred_taken_i(alloc_pred_taken_i),
    .alloc_pred_target_i(alloc_pred_target_i),
    .resolve_valid_i(resolve_valid_i), .resolve_is_branch_i(resolve_is_branch_i),
    .resolve_taken_i(resolve_taken_i), .resolve_target_i(resolve_target_i),
    .flush_i(flush_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o), .count_o(count_o),
    .update_o(update_o), .update_pc_o(update_pc_o), .actual_taken_o(actual_taken_o),
    .actual_target_o(actual_target_o), .is_branch_o(is_branch_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        av;  logic [31:0] apc; logic apt; logic [31:0] atg;
    logic        rv;  logic rb; logic rt; logic [31:0] rtg;
    logic        fl;
    int          e_cnt; logic e_mp; logic e_up;
    logic [31:0] e_rd; logic [31:0] e_upc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [31:0] apc, logic apt, logic [31:0] atg,
                              logic rv, logic rb, logic rt, logic [31:0] rtg,
                              int e_cnt, logic e_mp, logic e_up,
                              logic [31:0] e_rd, logic [31:0] e_upc);
    vec_t v;
    v.av = av; v.apc = apc; v.apt = apt; v.atg = atg;
    v.rv = rv; v.rb = rb; v.rt = rt; v.rtg = rtg; v.fl = 1'b0;
    v.e_cnt = e_cnt; v.e_mp = e_mp; v.e_up = e_up; v.e_rd = e_rd; v.e_upc = e_upc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    alloc_valid_i = 1'b0; alloc_pc_i = '0; alloc_pred_taken_i = 1'b0; alloc_pred_target_i = '0;
    resolve_valid_i = 1'b0; resolve_is_branch_i = 1'b0; resolve_taken_i = 1'b0;
    resolve_target_i = '0; flush_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    alloc_valid_i = v.av; alloc_pc_i = v.apc; alloc_pred_taken_i = v.apt;
    alloc_pred_target_i = v.atg;
    resolve_valid_i = v.rv; resolve_is_branch_i = v.rb; resolve_taken_i = v.rt;
    resolve_target_i = v.rtg; flush_i = v.fl;
    tick();
    chk({tag, " count"}, 32'(count_o), 32'(v.e_cnt));
    chk({tag, " ready"}, 32'(alloc_ready_o), 32'(v.e_cnt < DEPTH));
    chk({tag, " mispredict"}, 32'(mispredict_o), 32'(v.e_mp));
    chk({tag, " update"}, 32'(update_o), 32'(v.e_up));
    if (v.e_mp || v.e_up) chk({tag, " redirect"}, redirect_pc_o, v.e_rd);
    if (v.e_up) begin
      chk({tag, " update_pc"}, update_pc_o, v.e_upc);
      chk({tag, " actual_taken"}, 32'(actual_taken_o), 32'(v.rt));
      chk({tag, " actual_target"}, actual_target_o, v.rtg);
      chk({tag, " is_branch"}, 32'(is_branch_o), 32'd1);
    end
    drive_idle();
  endtask

  initial begin
    vec_t v;
    logic [31:0] pc;
    drive_idle();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset count", 32'(count_o), 32'd0);
    chk("reset ready", 32'(alloc_ready_o), 32'd1);
    chk("reset mispredict", 32'(mispredict_o), 32'd0);
    chk("reset update", 32'(update_o), 32'd0);
    chk("reset redirect", redirect_pc_o, 32'd0);
    rst_i = 1'b0;

    //        av apc           apt atg          rv rb rt rtg           cnt mp up redirect      upc
    // correct taken prediction
    vecs.push_back(mk(1, 32'h100, 1, 32'h200,  0, 0, 0, 32'h0,     1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 1, 1, 32'h200,   0, 0, 1, 32'h200,     32'h100));
    // direction mispredict kills younger entries
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,    0, 0, 0, 32'h0,     1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(1, 32'h104, 0, 32'h0,    0, 0, 0, 32'h0,     2, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(1, 32'h108, 0, 32'h0,    0, 0, 0, 32'h0,     3, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 1, 1, 32'h400,   0, 1, 1, 32'h400,     32'h100));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0,     0, 0, 0, 32'h0,       32'h0));
    // target mispredict, then taken-predicted fallthrough
    vecs.push_back(mk(1, 32'h100, 1, 32'h200,  0, 0, 0, 32'h0,     1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 1, 1, 32'h300,   0, 1, 1, 32'h300,     32'h100));
    vecs.push_back(mk(1, 32'h1FC, 1, 32'h500,  0, 0, 0, 32'h0,     1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 1, 0, 32'h0,     0, 1, 1, 32'h200,     32'h1FC));
    // fallthrough wraps at the top of the address space
    vecs.push_back(mk(1, 32'hFFFFFFFC, 0, 32'h0, 0, 0, 0, 32'h0,   1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 1, 0, 32'h1234,  0, 0, 1, 32'h0,       32'hFFFFFFFC));
    // phantom branch on a non-branch, then a harmless non-branch
    vecs.push_back(mk(1, 32'h80,  1, 32'h900,  0, 0, 0, 32'h0,     1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 0, 0, 32'h0,     0, 1, 0, 32'h84,      32'h0));
    vecs.push_back(mk(1, 32'h90,  0, 32'h0,    0, 0, 0, 32'h0,     1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 0, 0, 32'h0,     0, 0, 0, 32'h0,       32'h0));
    // resolve while empty is ignored
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 1, 1, 32'h700,   0, 0, 0, 32'h0,       32'h0));
    // same-cycle alloc + correct resolve
    vecs.push_back(mk(1, 32'h10,  1, 32'h20,   0, 0, 0, 32'h0,     1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(1, 32'h14,  0, 32'h0,    1, 1, 1, 32'h20,    1, 0, 1, 32'h20,      32'h10));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    1, 1, 0, 32'h0,     0, 0, 1, 32'h18,      32'h14));
    // same-cycle alloc dropped by a mispredict
    vecs.push_back(mk(1, 32'h30,  0, 32'h0,    0, 0, 0, 32'h0,     1, 0, 0, 32'h0,       32'h0));
    vecs.push_back(mk(1, 32'h34,  0, 32'h0,    1, 1, 1, 32'h40,    0, 1, 1, 32'h40,      32'h30));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,    0, 0, 0, 32'h0,     0, 0, 0, 32'h0,       32'h0));

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // full / wrap, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc = 32'h1000 + 32'(r) * 32'h100 + 32'(i) * 32'd4;
        alloc_valid_i = 1'b1; alloc_pc_i = pc;
        tick();
        exp_q.push_back(pc);
        drive_idle();
        chk($sformatf("fill r%0d count", r), 32'(count_o), 32'(i + 1));
        chk($sformatf("fill r%0d ready", r), 32'(alloc_ready_o), 32'(i < DEPTH - 1));
      end
      alloc_valid_i = 1'b1; alloc_pc_i = 32'hDEAD0000;
      tick();
      drive_idle();
      chk($sformatf("overflow r%0d count", r), 32'(count_o), 32'd8);
      chk($sformatf("overflow r%0d ready", r), 32'(alloc_ready_o), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
        resolve_valid_i = 1'b1; resolve_is_branch_i = 1'b1;
        resolve_target_i = 32'h5555;
        if (i == 0) begin
          alloc_valid_i = 1'b1; alloc_pc_i = 32'hBAD00000;
        end
        tick();
        drive_idle();
        pc = exp_q.pop_front();
        chk($sformatf("drain r%0d update_pc", r), update_pc_o, pc);
        chk($sformatf("drain r%0d update", r), 32'(update_o), 32'd1);
        chk($sformatf("drain r%0d mispredict", r), 32'(mispredict_o), 32'd0);
        chk($sformatf("drain r%0d redirect", r), redirect_pc_o, pc + 32'd4);
        chk($sformatf("drain r%0d count", r), 32'(count_o), 32'(DEPTH - 1 - i));
      end
    end

    // flush with same-cycle alloc and correct resolve
    v = mk(1, 32'h200, 1, 32'h300, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    apply_vec(v, "fl_a0");
    v = mk(1, 32'h204, 0, 32'h0, 0, 0, 0, 32'h0, 2, 0, 0, 32'h0, 32'h0);
    apply_vec(v, "fl_a1");
    v = mk(1, 32'h208, 0, 32'h0, 0, 0, 0, 32'h0, 3, 0, 0, 32'h0, 32'h0);
    apply_vec(v, "fl_a2");
    v = mk(1, 32'h20C, 0, 32'h0, 1, 1, 1, 32'h300, 0, 0, 1, 32'h300, 32'h200);
    v.fl = 1'b1;
    apply_vec(v, "fl_kill");
    v = mk(1, 32'h50, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    apply_vec(v, "fl_post_a");
    v = mk(0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 0, 1, 32'h54, 32'h50);
    apply_vec(v, "fl_post_r");

    // asynchronous reset mid-stream
    v = mk(1, 32'h600, 1, 32'h700, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    apply_vec(v, "rs_a0");
    v = mk(1, 32'h604, 0, 32'h0, 0, 0, 0, 32'h0, 2, 0, 0, 32'h0, 32'h0);
    apply_vec(v, "rs_a1");
    v = mk(0, 32'h0, 0, 32'h0, 1, 1, 1, 32'h700, 1, 0, 1, 32'h700, 32'h600);
    apply_vec(v, "rs_r0");
    #1 rst_i = 1'b1;
    #1;
    chk("async rst count", 32'(count_o), 32'd0);
    chk("async rst ready", 32'(alloc_ready_o), 32'd1);
    chk("async rst update", 32'(update_o), 32'd0);
    chk("async rst update_pc", update_pc_o, 32'd0);
    chk("async rst actual_target", actual_target_o, 32'd0);
    chk("async rst redirect", redirect_pc_o, 32'd0);
    chk("async rst is_branch", 32'(is_branch_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    v = mk(1, 32'h800, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    apply_vec(v, "post_rst_a");
    v = mk(0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0, 0, 0, 1, 32'h804, 32'h800);
    apply_vec(v, "post_rst_r");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_branch_resolve_queue
